// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter feeding a Moore "1101" sequence detector.
// Each frame is the sync word 1101, then the payload MSB-first, then an optional even-parity bit,
// then GAP_LEN idle zeros.
//
// Ports:
//   clk        - system clock, rising edge
//   n_rst      - synchronous active-low reset
//   load       - send request, accepted only while busy=0
//   data_in    - payload, captured on the accepting edge
//   o          - serial line (registered)
//   busy       - frame in progress (registered)
//   frame_done - one-cycle pulse in the final gap cycle (registered)
module sync_frame_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_LEN    = 2,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  o,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GapCntW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(DATA_WIDTH - 1);
  localparam logic [GapCntW-1:0] GapLast  = GapCntW'(GAP_LEN - 1);
  localparam logic [3:0]         SyncWord = 4'b1101;

  typedef enum logic [2:0] {StIdle, StSync, StData, StPar, StGap} state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_sync_idx, w_sync_idx_next;
  logic [BitCntW-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic [GapCntW-1:0]    r_gap_cnt, w_gap_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  r_par, w_par_next;
  logic                  r_o, w_o_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= StIdle;
      r_sync_idx <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_o        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sync_idx <= w_sync_idx_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_o        <= w_o_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // Next-state logic. Counters count down to zero and are reloaded on state entry.
  always_comb begin
    w_state_next    = r_state;
    w_sync_idx_next = r_sync_idx;
    w_bit_cnt_next  = r_bit_cnt;
    w_gap_cnt_next  = r_gap_cnt;
    w_shift_next    = r_shift;
    w_par_next      = r_par;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_state_next    = StSync;
          w_sync_idx_next = 2'd3;
          w_shift_next    = data_in;
          w_par_next      = ^data_in;
        end
      end
      StSync: begin
        if (r_sync_idx == 2'd0) begin
          w_state_next   = StData;
          w_bit_cnt_next = BitLast;
        end else begin
          w_sync_idx_next = r_sync_idx - 2'd1;
        end
      end
      StData: begin
        w_shift_next = r_shift << 1;
        if (r_bit_cnt == '0) begin
          if (PARITY_EN != 0) begin
            w_state_next = StPar;
          end else begin
            w_state_next   = StGap;
            w_gap_cnt_next = GapLast;
          end
        end else begin
          w_bit_cnt_next = r_bit_cnt - 1'b1;
        end
      end
      StPar: begin
        w_state_next   = StGap;
        w_gap_cnt_next = GapLast;
      end
      StGap: begin
        if (r_gap_cnt == '0) begin
          w_state_next = StIdle;
        end else begin
          w_gap_cnt_next = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it.
  // In DATA the line carries the MSB of the shift register as it will be after this edge.
  always_comb begin
    w_o_next = 1'b0;
    case (w_state_next)
      StSync:  w_o_next = SyncWord[w_sync_idx_next];
      StData:  w_o_next = w_shift_next[DATA_WIDTH-1];
      StPar:   w_o_next = w_par_next;
      default: w_o_next = 1'b0;
    endcase
    w_busy_next = (w_state_next != StIdle);
    w_done_next = (w_state_next == StGap) && (w_gap_cnt_next == '0);
  end

  assign o          = r_o;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Testbench for sync_frame_tx: two instances (parity on / parity off) share the stimulus.
// Expected per-cycle line values are queued when a frame is accepted and popped every cycle.
// A small Moore 1101 detector listens to the parity-enabled instance for the loopback case.
module tb_sync_frame_tx;

  localparam int unsigned Gap = 2;

  typedef logic [3:0] ent_t;  // {det, frame_done, busy, o}

  logic       clk;
  logic       n_rst;
  logic       load;
  logic [7:0] data_in;
  logic       o_p, busy_p, done_p;
  logic       o_n, busy_n, done_n;

  ent_t q_par[$];
  ent_t q_nopar[$];
  logic mbusy_par, mbusy_nopar;
  bit   det_chk;
  int   n_checks, n_errors;
  int   det_state;
  logic det;

  sync_frame_tx #(.DATA_WIDTH(8), .GAP_LEN(Gap), .PARITY_EN(1)) u_dut_par (
    .clk(clk), .n_rst(n_rst), .load(load), .data_in(data_in),
    .o(o_p), .busy(busy_p), .frame_done(done_p)
  );

  sync_frame_tx #(.DATA_WIDTH(8), .GAP_LEN(Gap), .PARITY_EN(0)) u_dut_nopar (
    .clk(clk), .n_rst(n_rst), .load(load), .data_in(data_in),
    .o(o_n), .busy(busy_n), .frame_done(done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moore 1101 detector: 0=none, 1="1", 2="11", 3="110", 4="1101" (output high).
  always @(posedge clk) begin
    if (!n_rst) det_state <= 0;
    else begin
      case (det_state)
        0: det_state <= o_p ? 1 : 0;
        1: det_state <= o_p ? 2 : 0;
        2: det_state <= o_p ? 2 : 3;
        3: det_state <= o_p ? 4 : 0;
        4: det_state <= o_p ? 2 : 0;
        default: det_state <= 0;
      endcase
    end
  end
  assign det = (det_state == 4);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_ent(input bit to_par, input ent_t e);
    if (to_par) q_par.push_back(e);
    else q_nopar.push_back(e);
  endtask

  // Expected line for one frame: 1101, payload MSB-first, optional even parity, Gap zeros.
  task automatic push_frame(input bit to_par, input logic [7:0] d, input bit pe);
    logic [3:0] sync;
    int         k;
    sync = 4'b1101;
    k    = 0;
    for (int i = 3; i >= 0; i--) begin
      push_ent(to_par, {1'b0, 1'b0, 1'b1, sync[i]});
      k++;
    end
    for (int i = 7; i >= 0; i--) begin
      // Detector reaches 1101 one edge after the last sync bit.
      push_ent(to_par, {(k == 4), 1'b0, 1'b1, d[i]});
      k++;
    end
    if (pe) push_ent(to_par, {1'b0, 1'b0, 1'b1, ^d});
    for (int i = 0; i < int'(Gap); i++) begin
      push_ent(to_par, {1'b0, (i == int'(Gap) - 1), 1'b1, 1'b0});
    end
  endtask

  task automatic cycle();
    ent_t ep, en;
    @(posedge clk);
    if (!n_rst) begin
      q_par.delete();
      q_nopar.delete();
    end else begin
      if (!mbusy_par && load)   push_frame(1'b1, data_in, 1'b1);
      if (!mbusy_nopar && load) push_frame(1'b0, data_in, 1'b0);
    end
    ep = '0;
    en = '0;
    if (q_par.size() > 0)   ep = q_par.pop_front();
    if (q_nopar.size() > 0) en = q_nopar.pop_front();
    mbusy_par   = ep[1];
    mbusy_nopar = en[1];
    #1;
    check_val("par_o", 32'(o_p), 32'(ep[0]));
    check_val("par_busy", 32'(busy_p), 32'(ep[1]));
    check_val("par_done", 32'(done_p), 32'(ep[2]));
    check_val("nopar_o", 32'(o_n), 32'(en[0]));
    check_val("nopar_busy", 32'(busy_n), 32'(en[1]));
    check_val("nopar_done", 32'(done_n), 32'(en[2]));
    if (det_chk) check_val("det", 32'(det), 32'(ep[3]));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    mbusy_par   = 1'b0;
    mbusy_nopar = 1'b0;
    det_chk     = 1'b0;
    n_rst       = 1'b0;
    load        = 1'b1;
    data_in     = 8'hA5;

    // Reset with load held high: nothing may start.
    repeat (2) cycle();
    n_rst = 1'b1;
    load  = 1'b0;
    repeat (3) cycle();

    // Single frame 0xA5 (even number of ones, parity 0).
    load    = 1'b1;
    data_in = 8'hA5;
    cycle();
    load = 1'b0;
    repeat (20) cycle();

    // Odd-parity payload.
    load    = 1'b1;
    data_in = 8'h01;
    cycle();
    load = 1'b0;
    repeat (20) cycle();

    // Load pulsed mid-frame with 0xFF must be ignored.
    load    = 1'b1;
    data_in = 8'h3C;
    cycle();
    load = 1'b0;
    repeat (5) cycle();
    load    = 1'b1;
    data_in = 8'hFF;
    repeat (2) cycle();
    load = 1'b0;
    repeat (15) cycle();

    // Load held continuously: back-to-back frames.
    load    = 1'b1;
    data_in = 8'h96;
    repeat (45) cycle();
    load = 1'b0;
    repeat (20) cycle();

    // Reset in the middle of the payload, then a fresh frame.
    load    = 1'b1;
    data_in = 8'h5A;
    cycle();
    load = 1'b0;
    repeat (8) cycle();
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    repeat (20) cycle();
    load    = 1'b1;
    data_in = 8'hC3;
    cycle();
    load = 1'b0;
    repeat (20) cycle();

    // Loopback into the detector with zero payload: one hit per frame.
    det_chk = 1'b1;
    load    = 1'b1;
    data_in = 8'h00;
    repeat (50) cycle();
    load = 1'b0;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter that produces the bit stream the team's Moore `1101` sequence detector consumes. On a load request it emits, one bit per clock, the 4-bit sync word `1101`, then a parallel payload MSB-first, then an optional even-parity bit, then a run of idle zeros. It sits at the transmit end of the single-wire serial link and uses a `busy`/`frame_done` handshake toward the upstream data source.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (legal range 1..32).
- `GAP_LEN`, 2: number of trailing zero bits after each frame (legal range 1..15).
- `PARITY_EN`, 1: 1 appends an even-parity bit after the payload; 0 omits it.
- `clk`  input  1  system clock; all logic is rising-edge.
- `n_rst`  input  1  reset, synchronous, active-low. Sampled on the `clk` rising edge; no asynchronous path.
- `load`  input  1  request to send `data_in`; honoured only while `busy`=0.
- `data_in`  input  DATA_WIDTH  payload, captured on the accepting edge.
- `o`  output  1  serial line, registered.
- `busy`  output  1  frame in progress, registered.
- `frame_done`  output  1  one-cycle pulse, registered.

## Operation
- States:
  - IDLE.
  - SYNC: 4 bits; a 2-bit index counts 3 down to 0.
  - DATA: DATA_WIDTH bits, taken from a shift register MSB-first.
  - PAR: 1 bit; skipped when PARITY_EN=0.
  - GAP: GAP_LEN zero bits.
- Transitions:
  - IDLE→SYNC when `load`=1. On that edge:
    - `data_in` is latched into the shift register.
    - Parity is computed as the XOR of `data_in` and latched.
  - SYNC→DATA after the index-0 bit.
  - DATA→PAR (or →GAP when PARITY_EN=0) after the last payload bit.
  - PAR→GAP after 1 cycle.
  - GAP→IDLE after GAP_LEN cycles.
- Outputs by state:
  - `o` = `1101`[index] in SYNC.
  - `o` = shift-register MSB in DATA. The register shifts left, zero-filling, once per DATA cycle.
  - `o` = latched parity in PAR.
  - `o` = 0 in GAP and IDLE.
- `busy`=1 in every state except IDLE.
- `frame_done`=1 only during the final GAP cycle.
- `load` while `busy`=1 is ignored. `data_in` is not sampled and no request is queued. The source must hold `load` until it sees `busy` rise.
- Counters use the minimum width for DATA_WIDTH and GAP_LEN. They do not wrap; each counter is reloaded on every state entry.
- Reset values (any edge with `n_rst`=0): state IDLE, `o`=0, `busy`=0, `frame_done`=0, shift register 0, parity 0, counters 0.
- Reset mid-frame aborts the frame immediately: no remaining bits are sent and `frame_done` does not pulse.
- If `load` and `n_rst`=0 occur on the same edge, reset wins and the load is dropped.

## Timing
- Accepting edge E (IDLE, `load`=1): the first sync bit appears on `o` and `busy`=1 in cycle E+1.
- Frame length L = 4 + DATA_WIDTH + PARITY_EN + GAP_LEN cycles. `busy` is high for cycles E+1 .. E+L.
- `frame_done` is high in cycle E+L only.
- The earliest next accept is edge E+L+1, where `busy`=0 is observed. The next first sync bit is then in cycle E+L+2, giving one IDLE cycle of `o`=0 between frames in addition to GAP.
- Latency from `load` to the detector's output `o`=1 is 5 cycles. The 4 sync bits land on E+1..E+4; the detector's registered state reaches RCV1101 one edge later.

## Test plan
- Reset: drive `n_rst`=0 for 2 edges with `load`=1 → `o`=0, `busy`=0, `frame_done`=0 throughout. No frame starts after reset releases until `load` is seen in IDLE.
- Single frame (DATA_WIDTH=8, PARITY_EN=1, GAP_LEN=2), `data_in`=0xA5:
  - `o` = 1,1,0,1, 1,0,1,0,0,1,0,1, 0, 0,0.
  - `busy` is high for exactly 15 cycles.
  - `frame_done` pulses once, in cycle 15.
- Odd parity payload `data_in`=0x01:
  - Parity bit = 1.
  - With PARITY_EN=0 the frame is 14 cycles and no parity bit is sent.
- `load` pulsed mid-frame with `data_in`=0xFF while sending 0x3C:
  - The 0x3C bits are unchanged.
  - 0xFF is never transmitted.
  - Holding `load`=1 continuously gives back-to-back frames separated by exactly GAP_LEN+1 zeros.
- Reset asserted during the DATA state (bit 4):
  - The next cycle shows `o`=0 and `busy`=0.
  - No `frame_done` pulse.
  - A fresh `load` then sends a complete frame.
- Loopback into the `1101` detector with `data_in`=0x00: the detector output goes high exactly once per frame, 5 cycles after the accepting edge.
